vxc_chunk_sequencer: RTL and testbench

VXC_CHUNK_SEQUENCER -- requirements
Module: vxc_chunk_sequencer

---
 rtl/vxc_chunk_sequencer_if.sv | 50 +++++
 rtl/vxc_chunk_sequencer.sv | 121 ++++++++++++
 tb/tb_vxc_chunk_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/vxc_chunk_sequencer_if.sv
// Chunk sequencer bus: start/op/constant command, source reads,
// chunk issue to the vXc unit, result writeback and status.
interface vxc_chunk_sequencer_if #(
   parameter int NOE           = 16,
   parameter int NI            = 8,
   parameter int element_width = 32
);
   localparam int NCH = (NOE + NI - 1) / NI;
   localparam int AW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int DW  = element_width * NI;

   logic                     start;
   logic                     op;
   logic [element_width-1:0] constant;
   logic                     rd_en;
   logic [AW-1:0]            rd_addr;
   logic [DW-1:0]            first_row_data;
   logic [DW-1:0]            second_row_data;
   logic                     issue_valid;
   logic [DW-1:0]            first_row_out;
   logic [DW-1:0]            second_row_out;
   logic [element_width-1:0] constant_out;
   logic                     op_out;
   logic [DW-1:0]            result_in;
   logic                     wr_en;
   logic [AW-1:0]            wr_addr;
   logic [DW-1:0]            wr_data;
   logic                     busy;
   logic                     done;

   modport master (
      input  start, op, constant,
      input  first_row_data, second_row_data, result_in,
      output rd_en, rd_addr,
      output issue_valid, first_row_out, second_row_out,
      output constant_out, op_out,
      output wr_en, wr_addr, wr_data,
      output busy, done
   );

   modport slave (
      output start, op, constant,
      output first_row_data, second_row_data, result_in,
      input  rd_en, rd_addr,
      input  issue_valid, first_row_out, second_row_out,
      input  constant_out, op_out,
      input  wr_en, wr_addr, wr_data,
      input  busy, done
   );
endinterface

// File: rtl/vxc_chunk_sequencer.sv
// Streams a vector pair chunk by chunk into a fixed-latency vXc unit
// and writes results back. Optional VXC_SEQ_ZERO_PAD_EN zeroes tail lanes.
module vxc_chunk_sequencer #(
   parameter int NOE           = 16,
   parameter int NI            = 8,
   parameter int element_width = 32,
   parameter int LATENCY       = 5
) (
   input logic                   clk,
   input logic                   reset,
   vxc_chunk_sequencer_if.master bus
);
   localparam int NCH = (NOE + NI - 1) / NI;
   localparam int AW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int DW  = element_width * NI;
   localparam logic [AW-1:0] LAST = AW'(NCH - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN
   } state_t;

   state_t state;

   // vp[0]: source data valid, vp[1]: issue, vp[LATENCY+1]: writeback
   logic [LATENCY+1:0] vp;
   logic [AW-1:0]      ap [LATENCY+2];
   logic [DW-1:0]      lane_mask;
   logic [DW-1:0]      first_pad;
   logic [DW-1:0]      second_pad;

   // Lane mask for the chunk whose source data is arriving now
   always_comb begin
      lane_mask = '1;
`ifdef VXC_SEQ_ZERO_PAD_EN
      for (int j = 0; j < NI; j++) begin
         if (int'(ap[0]) * NI + j >= NOE)
            lane_mask[element_width*(NI-j)-1 -: element_width] = '0;
      end
`endif
      first_pad  = bus.first_row_data & lane_mask;
      second_pad = bus.second_row_data & lane_mask;
   end

   // Control FSM: accept start, sweep chunk reads, wait for drain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         bus.rd_en        <= 1'b0;
         bus.rd_addr      <= '0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.op_out       <= 1'b0;
         bus.constant_out <= '0;
      end else begin
         bus.done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start && !bus.done) begin
                  bus.op_out       <= bus.op;
                  bus.constant_out <= bus.constant;
                  bus.busy         <= 1'b1;
                  bus.rd_en        <= 1'b1;
                  bus.rd_addr      <= '0;
                  state            <= READ;
               end
            end
            READ: begin
               if (bus.rd_addr == LAST) begin
                  bus.rd_en   <= 1'b0;
                  bus.rd_addr <= '0;
                  state       <= DRAIN;
               end else begin
                  bus.rd_addr <= bus.rd_addr + AW'(1);
               end
            end
            DRAIN: begin
               // only the final writeback stage may still be occupied
               if (vp[LATENCY:0] == '0) begin
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Valid/address pipeline from read strobe through writeback
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vp <= '0;
         for (int i = 0; i < LATENCY + 2; i++)
            ap[i] <= '0;
      end else begin
         vp    <= {vp[LATENCY:0], bus.rd_en};
         ap[0] <= bus.rd_addr;
         for (int i = 1; i < LATENCY + 2; i++)
            ap[i] <= ap[i-1];
      end
   end

   // Issue registers capture source chunks the cycle they arrive
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.first_row_out  <= '0;
         bus.second_row_out <= '0;
      end else if (vp[0]) begin
         bus.first_row_out  <= first_pad;
         bus.second_row_out <= second_pad;
      end
   end

   assign bus.issue_valid = vp[1];
   assign bus.wr_en       = vp[LATENCY+1];
   assign bus.wr_addr     = ap[LATENCY+1];
   assign bus.wr_data     = bus.wr_en ? bus.result_in : '0;

endmodule

// File: tb/tb_vxc_chunk_sequencer.sv
// Randomized self-checking bench for vxc_chunk_sequencer.
// Expected timing comes from the cycle formulas of the block's contract.
module tb_vxc_chunk_sequencer;
   localparam int NOE = 20;
   localparam int NI  = 8;
   localparam int EW  = 32;
   localparam int L   = 4;
   localparam int NCH = (NOE + NI - 1) / NI;
   localparam int DW  = EW * NI;
   localparam int END = NCH + L + 2;

   logic clk;
   logic reset;
   int   n_err;
   int   n_chk;

   logic [DW-1:0] src_a [NCH];
   logic [DW-1:0] src_b [NCH];
   logic [DW-1:0] res   [NCH];
   logic          lat_op;
   logic [EW-1:0] lat_c;

   vxc_chunk_sequencer_if #(
      .NOE(NOE), .NI(NI), .element_width(EW)
   ) bus ();

   vxc_chunk_sequencer #(
      .NOE(NOE), .NI(NI), .element_width(EW), .LATENCY(L)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_dw();
      logic [DW-1:0] v;
      for (int i = 0; i < NI; i++) v[EW*i +: EW] = EW'($urandom);
      return v;
   endfunction

   // Lane j of chunk k holds element k*NI+j
   function automatic logic [DW-1:0] pad(input logic [DW-1:0] d,
                                         input int k);
      logic [DW-1:0] v;
      v = d;
`ifdef VXC_SEQ_ZERO_PAD_EN
      for (int j = 0; j < NI; j++)
         if (k * NI + j >= NOE) v[EW*(NI-j)-1 -: EW] = '0;
`else
      if (k < 0) v = '0;
`endif
      return v;
   endfunction

   // Downstream vXc behaviour: a +/- constant*b per lane
   function automatic logic [DW-1:0] vxc(input logic [DW-1:0] a,
                                         input logic [DW-1:0] b,
                                         input logic [EW-1:0] c,
                                         input logic o);
      logic [DW-1:0] v;
      logic [EW-1:0] x, y;
      for (int j = 0; j < NI; j++) begin
         x = a[EW*(NI-j)-1 -: EW];
         y = b[EW*(NI-j)-1 -: EW];
         v[EW*(NI-j)-1 -: EW] = o ? x - c * y : x + c * y;
      end
      return v;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_rd_en"}, bus.rd_en, '0);
      chk({tag, "_rd_addr"}, bus.rd_addr, '0);
      chk({tag, "_issue"}, bus.issue_valid, '0);
      chk({tag, "_first"}, bus.first_row_out, '0);
      chk({tag, "_second"}, bus.second_row_out, '0);
      chk({tag, "_wr_en"}, bus.wr_en, '0);
      chk({tag, "_wr_addr"}, bus.wr_addr, '0);
      chk({tag, "_wr_data"}, bus.wr_data, '0);
      chk({tag, "_busy"}, bus.busy, '0);
      chk({tag, "_done"}, bus.done, '0);
      chk({tag, "_op"}, bus.op_out, '0);
      chk({tag, "_const"}, bus.constant_out, '0);
   endtask

   // One run: inj = extra start mid-run, chg = change op/constant,
   // dn = start in the done cycle, rst_at = cycle to pull reset (-1 none)
   task automatic run(input bit inj, input bit chg, input bit dn,
                      input int rst_at);
      bit ew, iv;
      @(negedge clk);
      for (int k = 0; k < NCH; k++) begin
         src_a[k] = rnd_dw();
         src_b[k] = rnd_dw();
      end
      lat_op = 1'($urandom);
      lat_c  = EW'($urandom_range(0, 15));
      for (int k = 0; k < NCH; k++)
         res[k] = vxc(pad(src_a[k], k), pad(src_b[k], k), lat_c, lat_op);
      bus.op       = lat_op;
      bus.constant = lat_c;
      bus.start    = 1'b1;
      for (int c = 0; c <= END + 1; c++) begin
         @(negedge clk);
         bus.start = (inj && c == 2) || (dn && c == END);
         if (chg && c == 1) begin
            bus.op       = ~lat_op;
            bus.constant = lat_c + EW'(5);
         end
         bus.first_row_data  = (c >= 1 && c <= NCH) ? src_a[c-1] : rnd_dw();
         bus.second_row_data = (c >= 1 && c <= NCH) ? src_b[c-1] : rnd_dw();
         ew = (c >= L + 2) && (c < END);
         bus.result_in = ew ? res[c-L-2] : rnd_dw();
         if (c == rst_at) begin
            reset = 1'b0;
            #1;
            chk_zero("mid_rst");
            break;
         end
         #1;
         iv = (c >= 2) && (c < NCH + 2);
         chk("rd_en", bus.rd_en, c < NCH);
         chk("rd_addr", bus.rd_addr, c < NCH ? c : 0);
         chk("issue_valid", bus.issue_valid, iv);
         if (iv) begin
            chk("first_out", bus.first_row_out, pad(src_a[c-2], c - 2));
            chk("second_out", bus.second_row_out, pad(src_b[c-2], c - 2));
         end
         chk("wr_en", bus.wr_en, ew);
         if (ew) begin
            chk("wr_addr", bus.wr_addr, c - L - 2);
            chk("wr_data", bus.wr_data, res[c-L-2]);
         end
         chk("busy", bus.busy, c < END);
         chk("done", bus.done, c == END);
         if (c <= END) begin
            chk("op_out", bus.op_out, lat_op);
            chk("const_out", bus.constant_out, lat_c);
         end
      end
      bus.start = 1'b0;
      if (rst_at >= 0) begin
         repeat (2) @(negedge clk);
         chk_zero("rst_hold");
         reset = 1'b1;
         for (int c = 0; c < 2 * END; c++) begin
            @(negedge clk);
            #1;
            chk("post_rst_wr_en", bus.wr_en, '0);
            chk("post_rst_rd_en", bus.rd_en, '0);
            chk("post_rst_busy", bus.busy, '0);
         end
      end
   endtask

   initial begin
      n_err = 0;
      n_chk = 0;
      reset = 1'b0;
      bus.start = 1'b0;
      bus.op = 1'b0;
      bus.constant = '0;
      bus.first_row_data = '0;
      bus.second_row_data = '0;
      bus.result_in = '0;
      repeat (3) @(negedge clk);
      #1;
      chk_zero("reset");
      reset = 1'b1;
      repeat (2) @(negedge clk);
      run(1'b0, 1'b0, 1'b0, -1);
      run(1'b1, 1'b0, 1'b0, -1);
      run(1'b0, 1'b1, 1'b0, -1);
      run(1'b0, 1'b0, 1'b1, -1);
      for (int i = 0; i < 8; i++)
         run(1'($urandom), 1'($urandom), 1'($urandom), -1);
      run(1'b0, 1'b0, 1'b0, 2);
      run(1'b0, 1'b0, 1'b0, -1);
      run(1'b1, 1'b1, 1'b1, -1);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
